// File: rtl/uart_rx_if.sv
// CPU-facing bundle of the UART receiver: serial line in, acknowledge in,
// status/data word out.
interface uart_rx_if;
   logic        rx;
   logic        clear;
   logic [15:0] out;

   modport master (output rx, output clear, input out);
   modport slave  (input rx, input clear, output out);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling of a synchronized RX line, received
// byte held in a {empty, ferr, ovr, 5'b0, data} word until the CPU clears it.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low (only once armed after reset)
// START | counting to mid start bit, rejects short glitches
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling stop bit mid-bit, commit byte or flag framing error
module uart_rx #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);

   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t     state, state_nxt;
   logic [7:0] clk_cnt, clk_cnt_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shift, shift_nxt;
   logic       frame_ok, frame_bad;

   logic [1:0] sync;
   logic [1:0] flush;
   logic       armed;
   logic       rx_s;

   logic       empty, ferr, ovr;
   logic [7:0] data;

   assign rx_s    = sync[1];
   assign bus.out = {empty, ferr, ovr, 5'b0, data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], bus.rx};
      end
   end

   // The synchronizer resets to 1, so a real high on the line is only trusted
   // once both stages hold pin samples; a frame caught mid-flight by reset is
   // thereby ignored until the line goes high and falls again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush <= 2'b00;
         armed <= 1'b0;
      end else begin
         flush <= {flush[0], 1'b1};
         if (flush[1] && rx_s) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         clk_cnt <= 8'd0;
         bit_cnt <= 3'd0;
         shift   <= 8'd0;
      end else begin
         state   <= state_nxt;
         clk_cnt <= clk_cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      frame_ok    = 1'b0;
      frame_bad   = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_nxt = 8'd0;
            bit_cnt_nxt = 3'd0;
            if (armed && !rx_s) begin
               state_nxt = START;
            end
         end
         START: begin
            if (clk_cnt == HALF) begin
               clk_cnt_nxt = 8'd0;
               bit_cnt_nxt = 3'd0;
               state_nxt   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + 8'd1;
            end
         end
         DATA: begin
            if (clk_cnt == LAST) begin
               clk_cnt_nxt = 8'd0;
               shift_nxt   = {rx_s, shift[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 8'd1;
            end
         end
         STOP: begin
            if (clk_cnt == LAST) begin
               clk_cnt_nxt = 8'd0;
               state_nxt   = IDLE;
               frame_ok    = rx_s;
               frame_bad   = !rx_s;
            end else begin
               clk_cnt_nxt = clk_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Later assignments win: a completing frame overrides a same-cycle clear
   // for empty/data, but only flags overrun if the CPU is not acknowledging.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         empty <= 1'b1;
         ferr  <= 1'b0;
         ovr   <= 1'b0;
         data  <= 8'd0;
      end else begin
         if (bus.clear) begin
            empty <= 1'b1;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
         end
         if (frame_ok) begin
            data  <= shift;
            empty <= 1'b0;
            if (!empty && !bus.clear) begin
               ovr <= 1'b1;
            end
         end
         if (frame_bad) begin
            ferr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames driven on the line, expected status words queued
// as each stimulus is issued and matched against every change of out.
module tb_uart_rx;

   localparam int CPB = 20;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;
   logic [15:0] exp_q[$];
   logic [15:0] prev_out;

   uart_rx_if bus();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Every change of out must match the oldest outstanding expectation.
   initial prev_out = 16'h8000;
   always @(negedge clk) begin
      if (bus.out !== prev_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", bus.out, prev_out);
         end else begin
            chk("out_change", bus.out, exp_q.pop_front());
         end
         prev_out = bus.out;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      bus.rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         idle(CPB);
      end
      if (stop_ok) begin
         bus.rx = 1'b1;
         idle(CPB);
      end else begin
         // Low just long enough to be sampled, so the line is high again
         // before a false start could pass its mid-bit check.
         bus.rx = 1'b0;
         idle(14);
         bus.rx = 1'b1;
         idle(CPB);
      end
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      idle(1);
      bus.clear = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget;
      budget = 3000;
      while (exp_q.size() != 0 && budget > 0) begin
         idle(1);
         budget--;
      end
      if (budget == 0) begin
         chk(tag, 16'(exp_q.size()), 16'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      reset     = 1'b1;
      bus.rx    = 1'b1;
      bus.clear = 1'b0;
      idle(3);
      chk("reset_out", bus.out, 16'h8000);
      reset = 1'b0;
      idle(10);
      chk("post_reset_idle", bus.out, 16'h8000);

      exp_q.push_back(16'h00A5);
      send_frame(8'hA5, 1'b1);
      idle(4);
      drain("timeout_a5");
      exp_q.push_back(16'h80A5);
      pulse_clear();
      idle(2);
      drain("timeout_clr_a5");

      exp_q.push_back(16'h0055);
      exp_q.push_back(16'h203C);
      send_frame(8'h55, 1'b1);
      send_frame(8'h3C, 1'b1);
      idle(4);
      drain("timeout_b2b");
      exp_q.push_back(16'h803C);
      pulse_clear();
      idle(2);
      drain("timeout_clr_b2b");

      bus.rx = 1'b0;
      idle(4);
      bus.rx = 1'b1;
      idle(40);
      chk("glitch_hold", bus.out, 16'h803C);
      exp_q.push_back(16'h007E);
      send_frame(8'h7E, 1'b1);
      idle(4);
      drain("timeout_7e");
      exp_q.push_back(16'h807E);
      pulse_clear();
      idle(2);
      drain("timeout_clr_7e");

      exp_q.push_back(16'hC07E);
      send_frame(8'h81, 1'b0);
      idle(4);
      drain("timeout_ferr");
      chk("ferr_hold", bus.out, 16'hC07E);
      exp_q.push_back(16'h807E);
      pulse_clear();
      idle(2);
      drain("timeout_clr_ferr");

      bus.rx = 1'b0;
      idle(CPB);
      bus.rx = 1'b1;
      idle(4 * CPB + CPB / 2);
      exp_q.push_back(16'h8000);
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(4 * CPB + CPB / 2);
      drain("timeout_reset");
      chk("reset_mid_frame", bus.out, 16'h8000);
      exp_q.push_back(16'h0012);
      send_frame(8'h12, 1'b1);
      idle(4);
      drain("timeout_12");
      exp_q.push_back(16'h8012);
      pulse_clear();
      idle(2);
      drain("timeout_clr_12");

      for (int b = 0; b < 256; b++) begin
         exp_q.push_back({8'h00, 8'(b)});
         send_frame(8'(b), 1'b1);
         idle(2);
         drain("timeout_loop");
         exp_q.push_back({8'h80, 8'(b)});
         pulse_clear();
         idle(2);
         drain("timeout_loop_clr");
      end

      idle(10);
      chk("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
